// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Only the FSM state encodings live here.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      SS_IDLE = 2'd0,
      SS_RUN  = 2'd1,
      SS_DONE = 2'd2
   } ss_state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder; the one arithmetic cell the serial subtractor reuses every cycle.
module full_adder (
   input  logic A,
   input  logic B,
   input  logic C,
   output logic sum,
   output logic carry
);

   assign sum   = A ^ B ^ C;
   assign carry = (A & B) | (C & (A ^ B));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B: one result bit per clock through a single full adder (A + ~B + 1).
// A start/done handshake frames each operation; results hold until the next run.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned SUB_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [SUB_WIDTH-1:0] A,
   input  logic [SUB_WIDTH-1:0] B,
   output logic [SUB_WIDTH-1:0] diff,
   output logic                 borrow,
   output logic                 overflow,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned     CntW    = $clog2(SUB_WIDTH);
   localparam logic [CntW-1:0] CntMsb  = CntW'(SUB_WIDTH - 2);
   localparam logic [CntW-1:0] CntLast = CntW'(SUB_WIDTH - 1);

   ss_state_e            r_state;
   ss_state_e            w_next_state;
   logic [SUB_WIDTH-1:0] r_a_sh;
   logic [SUB_WIDTH-1:0] r_b_sh;
   logic [SUB_WIDTH-1:0] r_diff;
   logic [CntW-1:0]      r_cnt;
   logic                 r_carry;
   logic                 r_c_msb_in;
   logic                 r_borrow;
   logic                 r_overflow;
   logic                 w_accept;
   logic                 w_last;
   logic                 w_b_inv;
   logic                 w_fa_sum;
   logic                 w_fa_carry;

   assign w_accept = start && ((r_state == SS_IDLE) || (r_state == SS_DONE));
   assign w_last   = (r_cnt == CntLast);
   assign w_b_inv  = ~r_b_sh[0];

   full_adder u_full_adder (
      .A     (r_a_sh[0]),
      .B     (w_b_inv),
      .C     (r_carry),
      .sum   (w_fa_sum),
      .carry (w_fa_carry)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= SS_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         SS_IDLE: if (start) w_next_state = SS_RUN;
         SS_RUN:  if (w_last) w_next_state = SS_DONE;
         SS_DONE: w_next_state = start ? SS_RUN : SS_IDLE;
         default: w_next_state = SS_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == SS_RUN);
      done = (r_state == SS_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a_sh     <= '0;
         r_b_sh     <= '0;
         r_diff     <= '0;
         r_cnt      <= '0;
         r_carry    <= 1'b0;
         r_c_msb_in <= 1'b0;
         r_borrow   <= 1'b0;
         r_overflow <= 1'b0;
      end else if (w_accept) begin
         r_a_sh  <= A;
         r_b_sh  <= B;
         r_diff  <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b1;
      end else if (r_state == SS_RUN) begin
         r_diff  <= {w_fa_sum, r_diff[SUB_WIDTH-1:1]};
         r_a_sh  <= r_a_sh >> 1;
         r_b_sh  <= r_b_sh >> 1;
         r_carry <= w_fa_carry;
         r_cnt   <= r_cnt + CntW'(1);
         // Carry leaving bit W-2 is the carry into the sign bit.
         if (r_cnt == CntMsb) begin
            r_c_msb_in <= w_fa_carry;
         end
         if (w_last) begin
            r_borrow   <= ~w_fa_carry;
            r_overflow <= r_c_msb_in ^ w_fa_carry;
         end
      end
   end

   assign diff     = r_diff;
   assign borrow   = r_borrow;
   assign overflow = r_overflow;

endmodule
